// File: rtl/gsensor_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gsensor_pkg
//  Description : Shared constants, FSM state type and address helpers for the
//                G-sensor SPI responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package gsensor_pkg;

    // Register map
    localparam logic [5:0] c_addr_devid       = 6'h00;
    localparam logic [5:0] c_addr_bw_rate     = 6'h2C;
    localparam logic [5:0] c_addr_power_ctl   = 6'h2D;
    localparam logic [5:0] c_addr_int_enable  = 6'h2E;
    localparam logic [5:0] c_addr_int_source  = 6'h30;
    localparam logic [5:0] c_addr_data_format = 6'h31;
    localparam logic [5:0] c_addr_datax0      = 6'h32;
    localparam logic [5:0] c_addr_datax1      = 6'h33;
    localparam logic [5:0] c_addr_datay0      = 6'h34;
    localparam logic [5:0] c_addr_datay1      = 6'h35;
    localparam logic [5:0] c_addr_dataz0      = 6'h36;
    localparam logic [5:0] c_addr_dataz1      = 6'h37;

    localparam logic [7:0] c_devid_default    = 8'hE5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } spi_state_t;

    // Registers whose content is owned by the sensor, not the SPI master
    function automatic logic is_read_only(input logic [5:0] addr);
        return (addr == c_addr_devid) || (addr == c_addr_int_source) ||
               ((addr >= c_addr_datax0) && (addr <= c_addr_dataz1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/gsensor_spi_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : gsensor_spi_responder_if
//  Description : SPI pins plus sample-injection and status signals of the
//                G-sensor responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gsensor_spi_responder_if;
    logic        sclk;
    logic        cs_n;
    logic        sdi;
    logic        sdo;
    logic        sdo_oe;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic [15:0] sample_z;
    logic        sample_valid;
    logic        int1;
    logic        busy;

    // Responder (sensor) side
    modport slave (
        input  sclk, cs_n, sdi, sample_x, sample_y, sample_z, sample_valid,
        output sdo, sdo_oe, int1, busy
    );

    // SPI master / stimulus side
    modport master (
        output sclk, cs_n, sdi, sample_x, sample_y, sample_z, sample_valid,
        input  sdo, sdo_oe, int1, busy
    );
endinterface
`default_nettype wire

// File: rtl/gsensor_spi_responder_spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Synchronizes sclk/cs_n/sdi into clk and produces single-clk
//                edge pulses. Edges are suppressed until the whole chain holds
//                post-reset samples, so a cs_n held low across reset never
//                looks like a fresh chip-select.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic arst,
    input  wire logic sclk,
    input  wire logic cs_n,
    input  wire logic sdi,
    output logic      sclk_rise,
    output logic      sclk_fall,
    output logic      cs_fall,
    output logic      cs_rise,
    output logic      sdi_s,
    output logic      cs_s
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   w_sclk_s;
    logic                   w_valid;

    // Synchronizer chains; idle levels (sclk high, cs_n high) on reset
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_sdi_sync  <= '0;
            r_sclk_d    <= 1'b1;
            r_cs_d      <= 1'b1;
            r_fill      <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= cs_s;
            r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign sdi_s     = r_sdi_sync[SYNC_STAGES-1];
    assign w_valid   = r_fill[SYNC_STAGES];

    assign sclk_rise = w_valid &  w_sclk_s & ~r_sclk_d;
    assign sclk_fall = w_valid & ~w_sclk_s &  r_sclk_d;
    assign cs_rise   = w_valid &  cs_s     & ~r_cs_d;
    assign cs_fall   = w_valid & ~cs_s     &  r_cs_d;

endmodule
`default_nettype wire

// File: rtl/gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : gsensor_spi_responder
//  Description : ADXL345-style SPI slave (CPOL=1, CPHA=1) with a 64x8 register
//                file, injected acceleration samples and DATA_READY on int1.
//  Revision    : 1.0 - initial release
// ============================================================================
module gsensor_spi_responder
    import gsensor_pkg::*;
#(
    parameter logic [7:0] DEVID_VAL     = c_devid_default,
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] RESET_BW_RATE = 8'h0A
) (
    input  wire logic              clk,
    input  wire logic              arst,
    gsensor_spi_responder_if.slave bus
);

    logic       w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_sdi_s, w_cs_s;
    logic       w_busy;

    spi_state_t r_state, w_state_nxt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift_in;
    logic [7:0] r_shift_out;
    logic [5:0] r_addr;
    logic       r_mb;
    logic       r_sdo;
    logic       r_sdo_oe;
    logic       r_rd_37;

    logic [7:0] r_regs [0:63];
    logic       r_data_ready;
    logic       r_int1;

    logic        r_pend;
    logic [15:0] r_pend_x, r_pend_y, r_pend_z;

    logic [7:0]  w_cmd;
    logic [5:0]  w_addr_adv;
    logic [7:0]  w_rd_data;
    logic        w_wr_en;
    logic        w_ld_direct;
    logic        w_ld;
    logic [15:0] w_ld_x, w_ld_y, w_ld_z;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk),
        .arst      (arst),
        .sclk      (bus.sclk),
        .cs_n      (bus.cs_n),
        .sdi       (bus.sdi),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .cs_fall   (w_cs_fall),
        .cs_rise   (w_cs_rise),
        .sdi_s     (w_sdi_s),
        .cs_s      (w_cs_s)
    );

    assign w_busy     = ~w_cs_s;
    assign w_cmd      = {r_shift_in[6:0], w_sdi_s};
    assign w_addr_adv = r_mb ? (r_addr + 6'd1) : r_addr;

    // Read mux: DEVID and INT_SOURCE are synthesized, everything else is RAM
    always_comb begin
        w_rd_data = r_regs[r_addr];
        if (r_addr == c_addr_devid)
            w_rd_data = DEVID_VAL;
        else if (r_addr == c_addr_int_source)
            w_rd_data = {r_data_ready, 7'b0};
    end

    assign w_wr_en = (r_state == ST_WRITE) && w_sclk_rise && (r_bit_cnt == 3'd7) &&
                     !w_cs_rise && !is_read_only(r_addr);

    // A fresh sample beats a buffered one; both only land while cs_n is high
    assign w_ld_direct = bus.sample_valid && !w_busy;
    assign w_ld        = w_ld_direct || (r_pend && !w_busy);
    assign w_ld_x      = w_ld_direct ? bus.sample_x : r_pend_x;
    assign w_ld_y      = w_ld_direct ? bus.sample_y : r_pend_y;
    assign w_ld_z      = w_ld_direct ? bus.sample_z : r_pend_z;

    // FSM state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state; chip-select release aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_CMD;
            ST_CMD:   if (w_sclk_rise && (r_bit_cnt == 3'd7))
                          w_state_nxt = w_cmd[7] ? ST_READ : ST_WRITE;
            default:  w_state_nxt = r_state;
        endcase
        if (w_cs_rise)
            w_state_nxt = ST_IDLE;
    end

    // Bit counter, shift registers, address pointer and sdo drive
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 8'h00;
            r_shift_out <= 8'h00;
            r_addr      <= 6'h00;
            r_mb        <= 1'b0;
            r_sdo       <= 1'b0;
            r_sdo_oe    <= 1'b0;
            r_rd_37     <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_bit_cnt <= 3'd0;
                r_rd_37   <= 1'b0;
            end
            case (r_state)
                ST_CMD: if (w_sclk_rise) begin
                    r_shift_in <= w_cmd;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_mb   <= w_cmd[6];
                        r_addr <= w_cmd[5:0];
                    end
                end
                ST_READ: if (w_sclk_fall) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd0) begin
                        r_sdo       <= w_rd_data[7];
                        r_shift_out <= {w_rd_data[6:0], 1'b0};
                        r_sdo_oe    <= 1'b1;
                        r_addr      <= w_addr_adv;
                        if (r_addr == c_addr_dataz1)
                            r_rd_37 <= 1'b1;
                    end else begin
                        r_sdo       <= r_shift_out[7];
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                    end
                end
                ST_WRITE: if (w_sclk_rise) begin
                    r_shift_in <= w_cmd;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        r_addr <= w_addr_adv;
                end
                default: ;
            endcase
            if (w_cs_rise) begin
                r_sdo    <= 1'b0;
                r_sdo_oe <= 1'b0;
            end
        end
    end

    // Register file: master writes and sample loads target disjoint addresses
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 64; i++)
                r_regs[i] <= 8'h00;
            r_regs[c_addr_bw_rate] <= RESET_BW_RATE;
        end else begin
            if (w_wr_en)
                r_regs[r_addr] <= w_cmd;
            if (w_ld) begin
                r_regs[c_addr_datax0] <= w_ld_x[7:0];
                r_regs[c_addr_datax1] <= w_ld_x[15:8];
                r_regs[c_addr_datay0] <= w_ld_y[7:0];
                r_regs[c_addr_datay1] <= w_ld_y[15:8];
                r_regs[c_addr_dataz0] <= w_ld_z[7:0];
                r_regs[c_addr_dataz1] <= w_ld_z[15:8];
            end
        end
    end

    // Pending buffer keeps burst reads coherent; newest sample overwrites
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pend   <= 1'b0;
            r_pend_x <= 16'h0000;
            r_pend_y <= 16'h0000;
            r_pend_z <= 16'h0000;
        end else if (bus.sample_valid && w_busy) begin
            r_pend   <= 1'b1;
            r_pend_x <= bus.sample_x;
            r_pend_y <= bus.sample_y;
            r_pend_z <= bus.sample_z;
        end else if (r_pend && !w_busy) begin
            r_pend   <= 1'b0;
        end
    end

    // DATA_READY: set by a load, cleared when a transaction that read DATAZ1 ends
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_data_ready <= 1'b0;
        else if (w_ld)
            r_data_ready <= 1'b1;
        else if (w_cs_rise && r_rd_37)
            r_data_ready <= 1'b0;
    end

    // int1 follows DATA_READY gated by INT_ENABLE bit 7
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_int1 <= 1'b0;
        else
            r_int1 <= r_data_ready & r_regs[c_addr_int_enable][7];
    end

    assign bus.sdo    = r_sdo;
    assign bus.sdo_oe = r_sdo_oe;
    assign bus.int1   = r_int1;
    assign bus.busy   = w_busy;

endmodule
`default_nettype wire
